pipe_ctrl: RTL
==============

# pipe_ctrl

Pipeline sequencing controller for the 5-stage RV32I core. It merges the load-use stall from the hazard unit, EX-stage branch redirects, instruction/data memory wait states and WB halt into per-stage register write-enables and flush/bubble controls. It also holds a pending redirect target while fetch is busy, and keeps saturating stall/flush performance counters.

## Interface
- `CNT_W`, default 16: width of each performance counter.
- `clk` in, 1: core clock; all state updates on the rising edge.
- `rst_n` in, 1: asynchronous, active-low reset.
- `ex_stall` in, 1: load-use stall from the hazard unit.
- `ex_redirect` in, 1: valid EX instruction resolved a taken or mispredicted branch or jump.
- `ex_redirect_pc` in, 32: redirect target from EX.
- `imem_ready` in, 1: fetch accepted this cycle.
- `dmem_req` in, 1: MEM-stage instruction is a valid load or store.
- `dmem_ready` in, 1: data access completes this cycle.
- `wb_halt` in, 1: valid ECALL/EBREAK in WB.
- `pc_we` out, 1: PC register write-enable.
- `pc_sel` out, 1: 0 = PC+4, 1 = `target_pc`.
- `target_pc` out, 32: redirect target presented to the PC mux.
- `if_id_we`, `id_ex_we`, `ex_mem_we`, `mem_wb_we` out, 1 each: pipeline register write-enables.
- `if_id_flush`, `id_ex_flush`, `ex_mem_bubble` out, 1 each: on write, load valid=0 into that register.
- `halted` out, 1: core halted (sticky).
- `stall_cnt` out, `CNT_W`: cycles with `pc_we`=0 while not halted.
- `flush_cnt` out, `CNT_W`: redirects accepted.

## Operation
- State register: RUN, MEM_WAIT, REDIRECT, HALT. Reset state is RUN.
- `redir_q` is a 32-bit latched target, reset value 0.
- Outputs are combinational from state, inputs and `redir_q`. Defaults: every `*_we` = 1, every flush/bubble = 0, `pc_sel` = 0, `target_pc` = `ex_redirect_pc`.
- Cases below are listed in priority order.
- `wb_halt` (any state except HALT):
  - Set all `*_we` = 0.
  - Next state HALT.
- Memory wait (`dmem_req` and not `dmem_ready`, any non-HALT state):
  - Set all `*_we` = 0.
  - Next state MEM_WAIT from RUN or MEM_WAIT; REDIRECT stays REDIRECT.
- MEM_WAIT with `dmem_ready`=1: evaluate as RUN this cycle; next state is determined by the RUN rules.
- RUN, `ex_stall`=1:
  - `pc_we` = `if_id_we` = `id_ex_we` = 0, `ex_mem_bubble` = 1; MEM and WB advance.
  - `ex_redirect` is ignored this cycle, because EX operands are stale.
- RUN, `ex_redirect`=1 (and no stall), with `imem_ready`=1:
  - `pc_sel` = 1, `pc_we` = 1.
  - `if_id_flush` = `id_ex_flush` = 1.
  - `flush_cnt` += 1.
  - Stay RUN.
- RUN, `ex_redirect`=1 (and no stall), with `imem_ready`=0:
  - `pc_we` = 0, `if_id_flush` = `id_ex_flush` = 1.
  - `redir_q` ← `ex_redirect_pc`.
  - `flush_cnt` += 1.
  - Next state REDIRECT.
- RUN, fetch busy (`imem_ready`=0, no redirect): `pc_we` = 0, `if_id_flush` = 1; downstream stages advance.
- REDIRECT:
  - `target_pc` = `redir_q`, `pc_sel` = 1, `if_id_flush` = 1 every cycle.
  - `ex_redirect` and `ex_stall` are ignored; the pipe front is empty.
  - `pc_we` = `imem_ready`. When `imem_ready` = 1, next state is RUN.
- HALT:
  - All `*_we` = 0, `halted` = 1. Exit only by reset.
- Counters saturate at 2^`CNT_W`−1 and never wrap.
- `halted` is registered: it is 1 from the cycle after `wb_halt` is accepted.

## Timing
- Enables and flushes are combinational: zero latency from inputs to outputs in the same cycle.
- State, `redir_q`, `halted` and counters update on the clock edge following the decision.
- Reset values (while `rst_n`=0 and after):
  - state RUN, `halted` 0, counters 0, `redir_q` 0.
  - While `rst_n`=0, all `*_we`, flushes, `ex_mem_bubble`, `pc_we` and `pc_sel` are forced to 0.
- Reset asserted mid-REDIRECT or mid-MEM_WAIT discards `redir_q` and the wait immediately; there is no glitch-through of enables.
- A load-use stall holds for exactly as many cycles as `ex_stall` is asserted. The hazard unit deasserts it after the load moves to WB, so the controller adds no cycles.
- `stall_cnt` increments in MEM_WAIT, REDIRECT and fetch-busy cycles, and whenever `ex_stall` is honoured.

## Test plan
- Load-use:
  - Stimulus: RUN, `ex_stall`=1 for one cycle, `ex_redirect`=1 in the same cycle.
  - Expect: `pc_we`=`if_id_we`=`id_ex_we`=0, `ex_mem_bubble`=1, `flush_cnt` unchanged, `stall_cnt` = 1.
- Redirect with fetch ready:
  - Stimulus: `ex_redirect`=1, `ex_redirect_pc`=0x0000_0100, `imem_ready`=1.
  - Expect: `pc_sel`=1, `target_pc`=0x100, both flushes 1, stays RUN, `flush_cnt` = 1.
- Redirect with fetch busy:
  - Stimulus: `ex_redirect`=1 with target 0x200 and `imem_ready`=0 for 3 cycles; `ex_redirect_pc` changes to 0x300 in cycle 2.
  - Expect: `target_pc` stays 0x200, `if_id_flush`=1 for all 3 cycles, `pc_we` rises when `imem_ready`=1, then RUN.
- Data wait:
  - Stimulus: `dmem_req`=1, `dmem_ready`=0 for 4 cycles with `ex_redirect`=1 held.
  - Expect: all `*_we`=0 for 4 cycles, `stall_cnt` = 4; on the ready cycle the redirect is taken.
- Halt:
  - Stimulus: `wb_halt`=1 during MEM_WAIT.
  - Expect: HALT; `halted`=1 next cycle; all enables stay 0 regardless of inputs until `rst_n` pulses low.
- Saturation and reset:
  - Stimulus: `CNT_W`=4, 20 fetch-busy cycles; then `rst_n` low mid-REDIRECT.
  - Expect: `stall_cnt` = 15 and holds; after reset all counters 0, state RUN, outputs 0 during reset.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller for the 5-stage RV32I core.
// Merges load-use stalls, EX redirects, memory wait states and WB halt into
// per-stage write-enables and flush/bubble controls. Holds a pending redirect
// target while fetch is busy and keeps saturating stall/flush counters.
module pipe_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ex_stall,
    input  logic             ex_redirect,
    input  logic [31:0]      ex_redirect_pc,
    input  logic             imem_ready,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    input  logic             wb_halt,
    output logic             pc_we,
    output logic             pc_sel,
    output logic [31:0]      target_pc,
    output logic             if_id_we,
    output logic             id_ex_we,
    output logic             ex_mem_we,
    output logic             mem_wb_we,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_bubble,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        REDIRECT = 2'd2,
        HALT     = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [31:0]      redir_q, redir_d;
    logic             halted_q, halted_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             flush_inc;

    // Priority decode: halt, memory wait, pending redirect, then RUN rules
    // (MEM_WAIT with the access completing is evaluated exactly like RUN).
    always_comb begin
        pc_we         = 1'b1;
        if_id_we      = 1'b1;
        id_ex_we      = 1'b1;
        ex_mem_we     = 1'b1;
        mem_wb_we     = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        ex_mem_bubble = 1'b0;
        pc_sel        = 1'b0;
        target_pc     = ex_redirect_pc;
        state_d       = state_q;
        redir_d       = redir_q;
        flush_inc     = 1'b0;

        // A parked redirect always owns the PC mux target.
        if (state_q == REDIRECT) begin
            target_pc = redir_q;
        end

        if (state_q == HALT) begin
            {pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we} = 5'b0;
        end else if (wb_halt) begin
            {pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we} = 5'b0;
            state_d = HALT;
        end else if (dmem_req && !dmem_ready) begin
            {pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we} = 5'b0;
            if (state_q != REDIRECT) begin
                state_d = MEM_WAIT;
            end
        end else if (state_q == REDIRECT) begin
            // Front of the pipe is empty: EX stall/redirect are meaningless here.
            pc_sel      = 1'b1;
            if_id_flush = 1'b1;
            pc_we       = imem_ready;
            if (imem_ready) begin
                state_d = RUN;
            end
        end else begin
            state_d = RUN;
            if (ex_stall) begin
                // EX operands are stale, so a redirect in this cycle is dropped.
                pc_we         = 1'b0;
                if_id_we      = 1'b0;
                id_ex_we      = 1'b0;
                ex_mem_bubble = 1'b1;
            end else if (ex_redirect) begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
                flush_inc   = 1'b1;
                if (imem_ready) begin
                    pc_sel = 1'b1;
                end else begin
                    pc_we   = 1'b0;
                    redir_d = ex_redirect_pc;
                    state_d = REDIRECT;
                end
            end else if (!imem_ready) begin
                pc_we       = 1'b0;
                if_id_flush = 1'b1;
            end
        end

        // No enable or flush may leak out while reset is held.
        if (!rst_n) begin
            pc_we         = 1'b0;
            if_id_we      = 1'b0;
            id_ex_we      = 1'b0;
            ex_mem_we     = 1'b0;
            mem_wb_we     = 1'b0;
            if_id_flush   = 1'b0;
            id_ex_flush   = 1'b0;
            ex_mem_bubble = 1'b0;
            pc_sel        = 1'b0;
        end
    end

    // Sticky halt flag and saturating performance counters.
    always_comb begin
        halted_d    = halted_q | (state_d == HALT);
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!pc_we && !halted_q && stall_cnt_q != CNT_MAX) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end
        if (flush_inc && flush_cnt_q != CNT_MAX) begin
            flush_cnt_d = flush_cnt_q + CNT_ONE;
        end
    end

    // State, pending target, halt flag and counters; reset discards all of them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            redir_q     <= 32'h0;
            halted_q    <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            redir_q     <= redir_d;
            halted_q    <= halted_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign halted    = halted_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule
